cache_refill_ctrl: RTL

Miss-handling sequencer for a set-associative cache that uses the FIFO replacement unit.
- On a miss it picks a victim way: the lowest invalid way if one exists, otherwise the replacement unit's index.
- If the victim is dirty, it writes the line back, then fetches the refill line and writes it into the arrays.
- Finally it updates the replacement state and signals completion to the pipeline.
- Sits between the cache lookup stage, the replacement unit and the memory bus interface.

---
 rtl/cache_refill_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: miss-handling sequencer for a set-associative cache.
// Picks a victim way, writes it back if dirty, fetches and fills the refill
// line, then updates the FIFO replacement state and pulses done.
// Optional build macro REFILL_PERF_CNT_EN adds miss / writeback counters.
module cache_refill_ctrl #(
  parameter int SET_ASSOC  = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          miss_valid,
  output logic                          miss_ready,
  input  logic [31:0]                   miss_addr,
  input  logic [SET_ASSOC-1:0]          way_valid,
  input  logic [SET_ASSOC-1:0]          way_dirty,
  input  logic [$clog2(SET_ASSOC)-1:0]  repl_index,
  output logic [SET_ASSOC-1:0]          repl_access,
  output logic                          repl_update,
  output logic                          wb_valid,
  input  logic                          wb_ready,
  output logic [$clog2(SET_ASSOC)-1:0]  wb_way,
  output logic [$clog2(LINE_WORDS)-1:0] wb_word,
  output logic                          wb_last,
  output logic                          rd_req,
  input  logic                          rd_req_ready,
  output logic [31:0]                   rd_addr,
  input  logic                          rd_valid,
  input  logic                          rd_last,
  output logic                          fill_we,
  output logic [$clog2(SET_ASSOC)-1:0]  fill_way,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word,
  output logic                          done
`ifdef REFILL_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_miss_cnt,
  output logic [31:0]                   perf_wb_cnt
`endif
);

  localparam int WAY_W  = $clog2(SET_ASSOC);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VICTIM, S_WB, S_RD_REQ, S_RD_DATA, S_COMMIT
  } state_t;

  state_t               state_q;
  logic [WORD_W-1:0]    cnt_q;
  logic [WAY_W-1:0]     victim_q;
  logic [31-OFF_W:0]    line_q;     // line-address bits of the missing address

  logic [WAY_W-1:0]     victim_d;
  logic                 victim_dirty;

  // Byte/word offset bits never leave the controller: refills are line aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_addr[OFF_W-1:0];

  // Lowest invalid way wins; a fully valid set defers to the replacement unit.
  function automatic logic [WAY_W-1:0] pick_victim(input logic [SET_ASSOC-1:0] vld,
                                                   input logic [WAY_W-1:0]     ridx);
    logic [WAY_W-1:0] v;
    logic             found;
    v     = ridx;
    found = 1'b0;
    for (int i = 0; i < SET_ASSOC; i++) begin
      if (!found && !vld[i]) begin
        v     = WAY_W'(i);
        found = 1'b1;
      end
    end
    return v;
  endfunction

  assign victim_d     = pick_victim(way_valid, repl_index);
  assign victim_dirty = way_valid[victim_d] & way_dirty[victim_d];

  // Miss sequencer: state, word counter, victim and latched line address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      victim_q <= '0;
      line_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (miss_valid) begin
            line_q  <= miss_addr[31:OFF_W];
            cnt_q   <= '0;
            state_q <= S_VICTIM;
          end
        end
        S_VICTIM: begin
          victim_q <= victim_d;
          state_q  <= victim_dirty ? S_WB : S_RD_REQ;
        end
        S_WB: begin
          if (wb_ready) begin
            if (cnt_q == LAST_WORD) begin
              cnt_q   <= '0;
              state_q <= S_RD_REQ;
            end else begin
              cnt_q <= cnt_q + WORD_W'(1);
            end
          end
        end
        S_RD_REQ: begin
          if (rd_req_ready) state_q <= S_RD_DATA;
        end
        S_RD_DATA: begin
          // rd_last alone ends the burst; the counter simply wraps on long bursts.
          if (rd_valid) begin
            cnt_q <= cnt_q + WORD_W'(1);
            if (rd_last) state_q <= S_COMMIT;
          end
        end
        S_COMMIT: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  // Output decode from the registered state; only fill_we follows rd_valid directly.
  always_comb begin
    miss_ready  = (state_q == S_IDLE);
    wb_valid    = (state_q == S_WB);
    wb_way      = wb_valid ? victim_q : '0;
    wb_word     = wb_valid ? cnt_q : '0;
    wb_last     = wb_valid && (cnt_q == LAST_WORD);
    rd_req      = (state_q == S_RD_REQ);
    rd_addr     = rd_req ? {line_q, {OFF_W{1'b0}}} : '0;
    fill_we     = (state_q == S_RD_DATA) && rd_valid;
    fill_way    = (state_q == S_RD_DATA) ? victim_q : '0;
    fill_word   = (state_q == S_RD_DATA) ? cnt_q : '0;
    done        = (state_q == S_COMMIT);
    repl_update = done;
    repl_access = done ? ({{(SET_ASSOC-1){1'b0}}, 1'b1} << victim_q) : '0;
  end

`ifdef REFILL_PERF_CNT_EN
  logic [31:0] perf_miss_cnt_q;
  logic [31:0] perf_wb_cnt_q;

  // Free-running event counters: accepted misses and dirty-victim writebacks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_miss_cnt_q <= '0;
      perf_wb_cnt_q   <= '0;
    end else begin
      if (state_q == S_IDLE && miss_valid)  perf_miss_cnt_q <= perf_miss_cnt_q + 32'd1;
      if (state_q == S_VICTIM && victim_dirty) perf_wb_cnt_q <= perf_wb_cnt_q + 32'd1;
    end
  end

  assign perf_miss_cnt = perf_miss_cnt_q;
  assign perf_wb_cnt   = perf_wb_cnt_q;
`endif

endmodule
